// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyph encodings are active-low {dp, g..a}; the dp bit is always 1 (off) here.
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam seg_t SEG_GLYPHS [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic seg_t seg_compose(input logic [6:0] glyph, input logic dp_on);
    return {~dp_on, glyph};
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // table lookup on the muxed digit value
  always_comb begin
    glyph = SEG_GLYPHS[nibble][6:0];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: scan prescaler, shadow/active
// double buffering committed on frame wrap, blink, blanking and leading-zero suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_suppress,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]        div_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [FRM_W-1:0]        frm_cnt_r;
  logic                    blink_phase_r;

  logic [4*NUM_DIGITS-1:0] sh_val_r;
  logic [NUM_DIGITS-1:0]   sh_dp_r;
  logic [NUM_DIGITS-1:0]   sh_blank_r;
  logic [NUM_DIGITS-1:0]   sh_blink_r;
  logic                    sh_lz_r;

  logic [4*NUM_DIGITS-1:0] act_val_r;
  logic [NUM_DIGITS-1:0]   act_dp_r;
  logic [NUM_DIGITS-1:0]   act_blank_r;
  logic [NUM_DIGITS-1:0]   act_blink_r;
  logic                    act_lz_r;

  logic                    pending_r;
  logic                    frame_start_r;
  seg_t                    seg_r;
  logic [NUM_DIGITS-1:0]   an_r;

  logic                    slot_wrap_s;
  logic                    frame_wrap_s;
  logic [NUM_DIGITS-1:0]   lz_dark_s;
  logic [3:0]              cur_val_s;
  logic                    cur_dark_s;
  logic [6:0]              glyph_s;
  seg_t                    seg_next_s;
  logic [NUM_DIGITS-1:0]   an_next_s;

  assign slot_wrap_s  = (div_cnt_r == DIV_LAST);
  assign frame_wrap_s = slot_wrap_s & (idx_r == IDX_LAST);

  // digit-slot prescaler and scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      idx_r     <= '0;
    end else if (slot_wrap_s) begin
      div_cnt_r <= '0;
      idx_r     <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // frame counter toggling the blink phase; phase 1 hides blinking digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_r     <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_wrap_s) begin
      if (frm_cnt_r == FRM_LAST) begin
        frm_cnt_r     <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frm_cnt_r <= frm_cnt_r + FRM_W'(1);
      end
    end
  end

  // shadow capture; a load on the wrap cycle stays pending for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val_r   <= '0;
      sh_dp_r    <= '0;
      sh_blank_r <= '1;
      sh_blink_r <= '0;
      sh_lz_r    <= 1'b0;
      pending_r  <= 1'b0;
    end else if (load) begin
      sh_val_r   <= digit_val;
      sh_dp_r    <= dp_en;
      sh_blank_r <= blank;
      sh_blink_r <= blink;
      sh_lz_r    <= lz_suppress;
      pending_r  <= 1'b1;
    end else if (frame_wrap_s) begin
      pending_r  <= 1'b0;
    end
  end

  // active register only changes at frame wrap, so a frame never mixes old and new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_r   <= '0;
      act_dp_r    <= '0;
      act_blank_r <= '1;
      act_blink_r <= '0;
      act_lz_r    <= 1'b0;
    end else if (frame_wrap_s) begin
      act_val_r   <= sh_val_r;
      act_dp_r    <= sh_dp_r;
      act_blank_r <= sh_blank_r;
      act_blink_r <= sh_blink_r;
      act_lz_r    <= sh_lz_r;
    end
  end

  // leading-zero chain from the leftmost digit down; digit 0 is never suppressed
  always_comb begin
    logic zero_run_v;
    zero_run_v = 1'b1;
    lz_dark_s  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_v   = zero_run_v & (act_val_r[4*i +: 4] == 4'h0) & ~act_dp_r[i];
      lz_dark_s[i] = act_lz_r & zero_run_v & (i != 0);
    end
  end

  assign cur_val_s  = act_val_r[{idx_r, 2'b00} +: 4];
  assign cur_dark_s = act_blank_r[idx_r]
                    | (act_blink_r[idx_r] & blink_phase_r)
                    | lz_dark_s[idx_r];

  seg_glyph_rom u_glyph_rom (
    .nibble (cur_val_s),
    .glyph  (glyph_s)
  );

  // next segment/anode pattern for the currently selected digit
  always_comb begin
    seg_next_s = SEG_BLANK;
    an_next_s  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r);
    if (cur_dark_s) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = seg_compose(glyph_s, act_dp_r[idx_r]);
    end
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r         <= SEG_BLANK;
      an_r          <= '1;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= seg_next_s;
      an_r          <= an_next_s;
      frame_start_r <= frame_wrap_s;
    end
  end

  assign seg         = seg_r;
  assign an          = an_r;
  assign pending     = pending_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, SCAN_DIV=4, BLINK_FRAMES=2)
// using a cycle-arithmetic reference model of what the display should show.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digit_val;
  logic [3:0]  dp_en;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        lz_suppress;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .digit_val   (digit_val),
    .dp_en       (dp_en),
    .blank       (blank),
    .blink       (blink),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .an          (an),
    .pending     (pending),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blk;
    logic [3:0]  bln;
    logic        lz;
  } disp_t;

  logic [7:0] glyphs [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  disp_t m_sh;
  disp_t m_act;
  logic  m_pend;
  int    k;
  int    vecs = 0;
  int    errs = 0;

  function automatic logic [7:0] exp_seg(input disp_t d, input int i, input logic phase);
    logic lead;
    lead = d.lz && (i != 0);
    for (int j = i; j < ND; j++) begin
      if (d.val[4*j +: 4] != 4'h0 || d.dp[j]) lead = 1'b0;
    end
    if (d.blk[i] || (d.bln[i] && phase) || lead) return 8'hFF;
    return {~d.dp[i], glyphs[d.val[4*i +: 4]][6:0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    m_sh   = '{val: 16'h0, dp: 4'h0, blk: 4'hF, bln: 4'h0, lz: 1'b0};
    m_act  = m_sh;
    m_pend = 1'b0;
    k      = 0;
  endtask

  task automatic cyc(input logic ld);
    int         idx;
    logic       ph;
    logic       bnd;
    logic [7:0] es;
    logic [3:0] ea;
    disp_t      nw;
    load = ld;
    @(posedge clk);
    k++;
    idx = ((k - 1) / SD) % ND;
    ph  = ((((k - 1) / FRAME) / BF) % 2) != 0;
    bnd = (k % FRAME) == 0;
    es  = exp_seg(m_act, idx, ph);
    ea  = 4'hF;
    ea[idx] = 1'b0;
    nw  = '{val: digit_val, dp: dp_en, blk: blank, bln: blink, lz: lz_suppress};
    if (bnd) begin
      m_act  = m_sh;
      m_pend = ld;
    end
    if (ld) begin
      m_sh   = nw;
      m_pend = 1'b1;
    end
    #1;
    check("seg", seg, es);
    check("an", {4'h0, an}, {4'h0, ea});
    check("pending", {7'h0, pending}, {7'h0, m_pend});
    check("frame_start", {7'h0, frame_start}, {7'h0, bnd});
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, seg, 8'hFF);
    check({tag, "_an"}, {4'h0, an}, 8'h0F);
    check({tag, "_pending"}, {7'h0, pending}, 8'h00);
    check({tag, "_frame_start"}, {7'h0, frame_start}, 8'h00);
  endtask

  initial begin
    rst_n       = 1'b0;
    load        = 1'b0;
    digit_val   = 16'h0;
    dp_en       = 4'h0;
    blank       = 4'h0;
    blink       = 4'h0;
    lz_suppress = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // idle scanning from reset: blanked digits, walking anode
    repeat (40) cyc(1'b0);

    // plain decode with decimal point on digit 0
    digit_val = 16'h1280; dp_en = 4'b0001; blank = 4'h0; blink = 4'h0; lz_suppress = 1'b0;
    cyc(1'b1);
    repeat (40) cyc(1'b0);

    // leading-zero suppression
    digit_val = 16'h0050; dp_en = 4'h0; lz_suppress = 1'b1;
    cyc(1'b1);
    repeat (36) cyc(1'b0);
    digit_val = 16'h0000;
    cyc(1'b1);
    repeat (36) cyc(1'b0);

    // blink on digit 3
    digit_val = 16'h1600; lz_suppress = 1'b0; blink = 4'b1000;
    cyc(1'b1);
    repeat (80) cyc(1'b0);

    // load exactly on the frame-boundary cycle
    while (((k + 1) % FRAME) != 0) cyc(1'b0);
    digit_val = 16'hABCD; blink = 4'h0; dp_en = 4'b1010;
    cyc(1'b1);
    repeat (36) cyc(1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      digit_val   = 16'($urandom);
      dp_en       = 4'($urandom);
      blank       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      blink       = 4'($urandom);
      lz_suppress = 1'($urandom);
      cyc($urandom_range(0, 7) == 0);
    end

    // asynchronous reset in the middle of a slot, with data pending
    digit_val = 16'h4321; dp_en = 4'h0; blank = 4'h0; blink = 4'h0; lz_suppress = 1'b0;
    cyc(1'b1);
    repeat (5) cyc(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (40) cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
